// File: rtl/subservient_debug_arbiter.sv
// Bus-ownership arbiter between the CPU and the debug host for the subservient debug switch.
// Hands the bus over only between Wishbone transactions and bounds debug-side waits with a timeout.
module subservient_debug_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_dbg_req,
    output logic o_dbg_gnt,
    output logic o_debug_mode,
    input  logic i_wb_dbus_stb,
    input  logic i_wb_dbg_stb,
    input  logic i_wb_mux_ack,
    output logic o_dbg_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_CPU,
        S_DRAIN,
        S_DEBUG,
        S_RELEASE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cpu_idle;
    logic          dbg_idle;
    logic          dbg_owned;
    logic          dbg_waiting;

    assign cpu_idle    = !i_wb_dbus_stb || i_wb_mux_ack;
    assign dbg_idle    = !i_wb_dbg_stb || i_wb_mux_ack || o_dbg_timeout;
    assign dbg_owned   = (state == S_DEBUG) || (state == S_RELEASE);
    assign dbg_waiting = dbg_owned && i_wb_dbg_stb && !i_wb_mux_ack;

    // NOTE: state and outputs update together with non-blocking assignments, so
    // every output is a flop and no input reaches an output combinationally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= S_CPU;
            o_debug_mode  <= 1'b0;
            o_dbg_gnt     <= 1'b0;
            o_dbg_timeout <= 1'b0;
            cnt           <= '0;
        end else begin
            case (state)
                S_CPU: begin
                    if (i_dbg_req && cpu_idle) begin
                        state        <= S_DEBUG;
                        o_debug_mode <= 1'b1;
                        o_dbg_gnt    <= 1'b1;
                    end else if (i_dbg_req) begin
                        state <= S_DRAIN;
                    end
                end
                // Once draining, the handover completes even if the request drops.
                S_DRAIN: begin
                    if (cpu_idle) begin
                        state        <= S_DEBUG;
                        o_debug_mode <= 1'b1;
                        o_dbg_gnt    <= 1'b1;
                    end
                end
                S_DEBUG: begin
                    if (!i_dbg_req && dbg_idle) begin
                        state        <= S_CPU;
                        o_debug_mode <= 1'b0;
                        o_dbg_gnt    <= 1'b0;
                    end else if (!i_dbg_req) begin
                        state     <= S_RELEASE;
                        o_dbg_gnt <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    if (dbg_idle) begin
                        state        <= S_CPU;
                        o_debug_mode <= 1'b0;
                    end
                end
                default: begin
                    state        <= S_CPU;
                    o_debug_mode <= 1'b0;
                    o_dbg_gnt    <= 1'b0;
                end
            endcase

            // Counter restarts at the hit so a held strobe times out every TIMEOUT cycles.
            if (dbg_waiting && (cnt == CNT_LAST)) begin
                cnt           <= '0;
                o_dbg_timeout <= 1'b1;
            end else if (dbg_waiting) begin
                cnt           <= cnt + CW'(1);
                o_dbg_timeout <= 1'b0;
            end else begin
                cnt           <= '0;
                o_dbg_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_subservient_debug_arbiter.sv
// Self-checking bench for subservient_debug_arbiter: directed timing scenarios plus
// randomized traffic compared against a transaction-level ownership model.
module tb_subservient_debug_arbiter;

    localparam int TIMEOUT = 4;

    logic clk;
    logic rst;
    logic dbg_req;
    logic dbg_gnt;
    logic debug_mode;
    logic dbus_stb;
    logic dbg_stb;
    logic mux_ack;
    logic dbg_timeout;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the bus, whether a handover is pending, and how
    // many consecutive cycles the debug strobe has been left unanswered.
    bit m_mode;
    bit m_gnt;
    bit m_to;
    bit m_drain;
    int m_wait;

    subservient_debug_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_dbg_req     (dbg_req),
        .o_dbg_gnt     (dbg_gnt),
        .o_debug_mode  (debug_mode),
        .i_wb_dbus_stb (dbus_stb),
        .i_wb_dbg_stb  (dbg_stb),
        .i_wb_mux_ack  (mux_ack),
        .o_dbg_timeout (dbg_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_mode  = 1'b0;
        m_gnt   = 1'b0;
        m_to    = 1'b0;
        m_drain = 1'b0;
        m_wait  = 0;
    endtask

    // Advance one clock; the model steps on the same edge using the inputs of the ending cycle.
    task automatic step();
        bit n_mode, n_gnt, n_to, n_drain, cpu_busy, dbg_busy;
        int n_wait;
        n_mode   = m_mode;
        n_gnt    = m_gnt;
        n_drain  = m_drain;
        n_to     = 1'b0;
        n_wait   = 0;
        cpu_busy = dbus_stb && !mux_ack;
        dbg_busy = dbg_stb && !mux_ack && !m_to;
        if (!m_mode) begin
            if ((dbg_req || m_drain) && !cpu_busy) begin
                n_mode  = 1'b1;
                n_gnt   = 1'b1;
                n_drain = 1'b0;
            end else begin
                n_drain = dbg_req || m_drain;
            end
        end else begin
            if ((!m_gnt || !dbg_req) && !dbg_busy) begin
                n_mode = 1'b0;
                n_gnt  = 1'b0;
            end else if (!dbg_req) begin
                n_gnt = 1'b0;
            end
            if (dbg_stb && !mux_ack) begin
                n_wait = m_wait + 1;
                n_to   = (n_wait % TIMEOUT) == 0;
            end
        end
        @(posedge clk);
        m_mode  = n_mode;
        m_gnt   = n_gnt;
        m_to    = n_to;
        m_drain = n_drain;
        m_wait  = n_wait;
        #1;
    endtask

    task automatic do_reset();
        dbg_req  = 1'b0;
        dbus_stb = 1'b0;
        dbg_stb  = 1'b0;
        mux_ack  = 1'b0;
        rst      = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic enter_debug();
        dbg_req = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        enter_debug();
        #3 rst = 1'b1;
        #1;
        total++;
        if ({debug_mode, dbg_gnt, dbg_timeout} !== 3'b000) begin
            bad++;
            $display("FAIL reset_async: got mode/gnt/to=%b want 000", {debug_mode, dbg_gnt, dbg_timeout});
        end
        dbg_req = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({debug_mode, dbg_gnt, dbg_timeout} !== 3'b000) begin
                bad++;
                $display("FAIL reset_release[%0d]: got %b want 000", i, {debug_mode, dbg_gnt, dbg_timeout});
            end
        end
    endtask

    task automatic test_idle_grant();
        do_reset();
        repeat (3) step();
        dbg_req = 1'b1;
        step();
        total++;
        if ({debug_mode, dbg_gnt} !== 2'b11) begin
            bad++;
            $display("FAIL idle_grant: got mode/gnt=%b want 11", {debug_mode, dbg_gnt});
        end
        repeat (5) step();
        dbg_req = 1'b0;
        step();
        total++;
        if ({debug_mode, dbg_gnt} !== 2'b00) begin
            bad++;
            $display("FAIL idle_release: got mode/gnt=%b want 00", {debug_mode, dbg_gnt});
        end
    endtask

    task automatic test_drain();
        do_reset();
        dbus_stb = 1'b1;
        step();
        dbg_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({debug_mode, dbg_gnt} !== 2'b00) begin
                bad++;
                $display("FAIL drain_hold[%0d]: got mode/gnt=%b want 00", i, {debug_mode, dbg_gnt});
            end
        end
        mux_ack = 1'b1;
        #1;
        total++;
        if (debug_mode !== 1'b0) begin
            bad++;
            $display("FAIL drain_ack_cycle: got mode=%b want 0", debug_mode);
        end
        step();
        mux_ack  = 1'b0;
        dbus_stb = 1'b0;
        total++;
        if ({debug_mode, dbg_gnt} !== 2'b11) begin
            bad++;
            $display("FAIL drain_grant: got mode/gnt=%b want 11", {debug_mode, dbg_gnt});
        end
        // A drain that loses its request still hands over, then releases at once.
        do_reset();
        dbus_stb = 1'b1;
        dbg_req  = 1'b1;
        step();
        dbg_req = 1'b0;
        mux_ack = 1'b1;
        step();
        mux_ack  = 1'b0;
        dbus_stb = 1'b0;
        total++;
        if ({debug_mode, dbg_gnt} !== 2'b11) begin
            bad++;
            $display("FAIL drain_dropped_req: got mode/gnt=%b want 11", {debug_mode, dbg_gnt});
        end
        step();
        total++;
        if ({debug_mode, dbg_gnt} !== 2'b00) begin
            bad++;
            $display("FAIL drain_dropped_release: got mode/gnt=%b want 00", {debug_mode, dbg_gnt});
        end
    endtask

    task automatic test_simultaneous_ack();
        do_reset();
        dbus_stb = 1'b1;
        step();
        dbg_req = 1'b1;
        mux_ack = 1'b1;
        step();
        mux_ack  = 1'b0;
        dbus_stb = 1'b0;
        total++;
        if ({debug_mode, dbg_gnt} !== 2'b11) begin
            bad++;
            $display("FAIL simultaneous_ack: got mode/gnt=%b want 11", {debug_mode, dbg_gnt});
        end
    endtask

    task automatic test_deferred_release();
        do_reset();
        enter_debug();
        dbg_stb = 1'b1;
        step();
        dbg_req = 1'b0;
        step();
        total++;
        if ({debug_mode, dbg_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL deferred_gnt_drop: got mode/gnt=%b want 10", {debug_mode, dbg_gnt});
        end
        step();
        mux_ack = 1'b1;
        #1;
        total++;
        if (debug_mode !== 1'b1) begin
            bad++;
            $display("FAIL deferred_mode_held: got mode=%b want 1", debug_mode);
        end
        step();
        mux_ack = 1'b0;
        dbg_stb = 1'b0;
        total++;
        if ({debug_mode, dbg_gnt, dbg_timeout} !== 3'b000) begin
            bad++;
            $display("FAIL deferred_mode_drop: got mode/gnt/to=%b want 000", {debug_mode, dbg_gnt, dbg_timeout});
        end
    endtask

    task automatic test_timeout();
        do_reset();
        enter_debug();
        dbg_stb = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            total++;
            if (dbg_timeout !== ((k % TIMEOUT) == 0)) begin
                bad++;
                $display("FAIL timeout_pulse[S+%0d]: got %b want %b", k, dbg_timeout, (k % TIMEOUT) == 0);
            end
        end
        dbg_stb = 1'b0;
        dbg_req = 1'b0;
        step();
        // Timeout also ends a pending access during release.
        enter_debug();
        dbg_stb = 1'b1;
        dbg_req = 1'b0;
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            step();
            total++;
            if (debug_mode !== (k <= TIMEOUT)) begin
                bad++;
                $display("FAIL release_timeout_mode[S+%0d]: got %b want %b", k, debug_mode, k <= TIMEOUT);
            end
        end
        dbg_stb = 1'b0;
    endtask

    task automatic test_ack_race();
        do_reset();
        enter_debug();
        dbg_stb = 1'b1;
        for (int k = 1; k <= TIMEOUT + 3; k++) begin
            mux_ack = (k == TIMEOUT);
            step();
            total++;
            if (dbg_timeout !== 1'b0) begin
                bad++;
                $display("FAIL ack_race[S+%0d]: got timeout=%b want 0", k, dbg_timeout);
            end
        end
        mux_ack = 1'b0;
        dbg_stb = 1'b0;
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        dbus_stb = 1'b1;
        dbg_req  = 1'b1;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({debug_mode, dbg_gnt} !== 2'b00) begin
            bad++;
            $display("FAIL reset_drain_async: got mode/gnt=%b want 00", {debug_mode, dbg_gnt});
        end
        dbg_req = 1'b0;
        step();
        rst = 1'b0;
        step();
        mux_ack = 1'b1;
        step();
        mux_ack  = 1'b0;
        dbus_stb = 1'b0;
        total++;
        if ({debug_mode, dbg_gnt} !== 2'b00) begin
            bad++;
            $display("FAIL reset_drain_forgotten: got mode/gnt=%b want 00", {debug_mode, dbg_gnt});
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (($urandom % 20) == 0) dbg_req = !dbg_req;
            dbus_stb = ($urandom % 2) == 0;
            dbg_stb  = ($urandom % 4) != 0;
            mux_ack  = ($urandom % 5) == 0;
            step();
            total++;
            if ({debug_mode, dbg_gnt, dbg_timeout} !== {m_mode, m_gnt, m_to}) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: got mode/gnt/to=%b want %b", c,
                             {debug_mode, dbg_gnt, dbg_timeout}, {m_mode, m_gnt, m_to});
            end
        end
        dbg_req = 1'b0;
        dbus_stb = 1'b0;
        dbg_stb  = 1'b0;
        mux_ack  = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        dbg_req  = 1'b0;
        dbus_stb = 1'b0;
        dbg_stb  = 1'b0;
        mux_ack  = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_idle_grant();
        test_drain();
        test_simultaneous_ack();
        test_deferred_release();
        test_timeout();
        test_ack_race();
        test_reset_in_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/subservient_debug_arbiter.md
# subservient_debug_arbiter

Sequences ownership of the shared data bus between the CPU and the debug host. It drives the select line of the subservient debug switch, so control never changes while a Wishbone transaction is outstanding. It also bounds debug-side transactions with a timeout so a missing slave cannot hang the debug host. It sits beside the debug switch in the subservient SoC top level and observes the CPU-side and debug-side strobes and the shared ack.

## Interface

- TIMEOUT, default 255: number of consecutive cycles a debug strobe may wait for ack before a forced timeout; legal range 1..65535.
- i_clk  in  1  clock; all state on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_dbg_req  in  1  debug host requests bus ownership (level; held for the whole debug session).
- o_dbg_gnt  out  1  debug host owns the bus; host may assert stb only while high.
- o_debug_mode  out  1  select line to the debug switch (1 = debug host drives memory bus).
- i_wb_dbus_stb  in  1  CPU data bus strobe (pre-switch).
- i_wb_dbg_stb  in  1  debug host strobe (pre-switch).
- i_wb_mux_ack  in  1  ack from memory/peripheral side of the switch.
- o_dbg_timeout  out  1  one-cycle pulse: current debug transaction abandoned; host treats as error-terminated ack.

## Operation

- Definitions:
  - cpu_idle = !i_wb_dbus_stb | i_wb_mux_ack, evaluated while o_debug_mode = 0.
  - dbg_idle = !i_wb_dbg_stb | i_wb_mux_ack | timeout_hit.
- Four-state FSM, registered; all outputs are decoded from registered state (no combinational input-to-output path).
  - CPU: mode=0, gnt=0. If i_dbg_req & cpu_idle -> DEBUG. If i_dbg_req & !cpu_idle -> DRAIN. Otherwise stay.
  - DRAIN: mode=0, gnt=0. Waits for the outstanding CPU transaction to finish. If cpu_idle -> DEBUG, even if i_dbg_req has dropped; DEBUG then immediately releases. Never aborts a CPU transaction and has no timeout.
  - DEBUG: mode=1, gnt=1. If !i_dbg_req & dbg_idle -> CPU. If !i_dbg_req & !dbg_idle -> RELEASE. Otherwise stay.
  - RELEASE: mode=1, gnt=0. If dbg_idle -> CPU.
- Timeout counter, width $clog2(TIMEOUT+1):
  - Active in DEBUG and RELEASE only.
  - Increments each cycle i_wb_dbg_stb=1 & i_wb_mux_ack=0.
  - Clears on ack, when stb is low, on timeout_hit, and in CPU/DRAIN.
  - timeout_hit is registered: o_dbg_timeout=1 for exactly one cycle when the counter has reached TIMEOUT-1 with stb still high and no ack.
  - If ack and timeout_hit coincide, ack wins: no o_dbg_timeout pulse.
- The CPU is stalled, not errored, while in debug mode: the switch masks its ack, and its strobe is ignored until mode returns to 0.
- Reset values: state=CPU, o_debug_mode=0, o_dbg_gnt=0, o_dbg_timeout=0, counter=0.
- Asserting i_rst mid-session returns immediately to CPU/mode 0, with no drain. Any in-flight transaction is lost by design.

## Timing

- Request with CPU idle: i_dbg_req rises in cycle N with cpu_idle=1 -> o_debug_mode=o_dbg_gnt=1 in N+1.
- Request during CPU access: DRAIN from N+1; ack seen in cycle K -> mode/gnt=1 in K+1. The acked CPU transaction completes with mode still 0.
- Release with no debug access pending: i_dbg_req falls in M -> mode=gnt=0 in M+1.
- Release with debug access pending: gnt=0 in M+1. Mode stays 1 until the cycle after the pending ack or timeout.
- Timeout: stb rises in cycle S with no ack -> o_dbg_timeout pulse in cycle S+TIMEOUT.
- Simultaneous i_dbg_req rise and CPU ack in the same cycle: cpu_idle=1, so go directly to DEBUG.

## Test plan

- Reset: assert i_rst asynchronously mid-cycle -> all outputs 0 immediately; hold 3 cycles, release -> outputs stay 0.
- Idle grant: dbus_stb=0, raise i_dbg_req at cycle 10 -> mode=gnt=1 at cycle 11. Drop req at 20 -> both 0 at 21.
- Drain: dbus_stb=1 from cycle 5, req at 6, ack at 9 -> mode/gnt stay 0 through 9, rise at 10. No ack reaches the debug side.
- Deferred release: in DEBUG, dbg_stb=1 at 30, req drops at 31, ack at 34 -> gnt=0 at 32, mode=1 until 34, mode=0 at 35.
- Timeout: TIMEOUT=4, in DEBUG dbg_stb=1 from cycle 50, no ack -> o_dbg_timeout pulse only at 54. Counter restarts, next pulse at 58 if stb is held.
- Ack/timeout race: TIMEOUT=4, stb at 50, ack at 53 -> no pulse. Reset mid-DRAIN -> state CPU, mode 0.
